// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seven_seg_pkg;

  localparam int SEG_VAL_W = 32;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  function automatic int cnt_width(input int dwell);
    return $clog2(dwell);
  endfunction

endpackage

// File: rtl/seven_seg_rr_pick.sv
// Round-robin search: first asserted req at or after start, wrapping.
// Latency: combinational.
// Backpressure: none.
module seven_seg_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic [N_REQ-1:0]         winner,
  output logic                     valid
);

  localparam int IDX_W = $clog2(N_REQ);

  int               sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(start) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IDX_W'(sum);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Time-shares the 8-digit display among requesters: round-robin dwell, req 0 preempts.
// Latency: 1 cycle from req_in/val_in to grant_out/val_out; all outputs registered.
// Backpressure: none; requesters hold req_in level, hold_in freezes rotation.
module seven_seg_display_arbiter
  import seven_seg_pkg::*;
#(
  parameter int                   N_REQ        = 4,
  parameter int                   DWELL_CYCLES = 100_000_000,
  parameter logic [SEG_VAL_W-1:0] IDLE_VAL     = 32'h0000_0000
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [N_REQ-1:0]             req_in,
  input  logic [SEG_VAL_W*N_REQ-1:0]   val_in,
  input  logic                         hold_in,
  output logic [SEG_VAL_W-1:0]         val_out,
  output logic [N_REQ-1:0]             grant_out,
  output logic                         switch_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(DWELL_CYCLES);

  state_t              state, nstate;
  logic [CNT_W-1:0]    cnt, ncnt;
  logic [IDX_W-1:0]    last_ptr, nidx, pick_start;
  logic                req0_q;
  logic [N_REQ-1:0]    ngrant, pick_win;
  logic                pick_vld, rise0, expiry, is_new;
  logic [SEG_VAL_W-1:0] nval;

  // last_ptr always equals the current grant while showing, so one search serves both cases
  assign pick_start = (last_ptr == IDX_W'(N_REQ-1)) ? '0 : last_ptr + IDX_W'(1);

  seven_seg_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req_in),
    .start  (pick_start),
    .winner (pick_win),
    .valid  (pick_vld)
  );

  assign rise0  = req_in[0] & ~req0_q;
  assign expiry = (cnt == CNT_W'(DWELL_CYCLES-1)) && !hold_in;

  always_comb begin
    nstate = state;
    ngrant = grant_out;
    ncnt   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          nstate = SHOW;
          ngrant = pick_win;
          ncnt   = '0;
        end
      end
      SHOW: begin
        if (rise0 && !grant_out[0]) begin
          ngrant = {{(N_REQ-1){1'b0}}, 1'b1};
          ncnt   = '0;
        end else if ((req_in & grant_out) == '0) begin
          ncnt = '0;
          if (pick_vld) begin
            ngrant = pick_win;
          end else begin
            nstate = IDLE;
            ngrant = '0;
          end
        end else if (expiry) begin
          // searching from current+1 wraps back to current when it is the only one active
          ngrant = pick_win;
          ncnt   = '0;
        end else if (!hold_in) begin
          ncnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        nstate = IDLE;
        ngrant = '0;
        ncnt   = '0;
      end
    endcase
  end

  always_comb begin
    nidx = '0;
    nval = IDLE_VAL;
    for (int i = 0; i < N_REQ; i++) begin
      if (ngrant[i]) begin
        nidx = IDX_W'(i);
        nval = val_in[i*SEG_VAL_W +: SEG_VAL_W];
      end
    end
  end

  assign is_new = (ngrant != '0) && (ngrant != grant_out);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      grant_out  <= '0;
      val_out    <= IDLE_VAL;
      switch_out <= 1'b0;
      cnt        <= '0;
      last_ptr   <= IDX_W'(N_REQ-1);
      req0_q     <= 1'b0;
    end else begin
      state      <= nstate;
      grant_out  <= ngrant;
      val_out    <= nval;
      switch_out <= is_new;
      cnt        <= ncnt;
      req0_q     <= req_in[0];
      if (is_new) last_ptr <= nidx;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Scoreboard bench for seven_seg_display_arbiter with N_REQ=4, DWELL_CYCLES=8.
module tb_seven_seg_display_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [N-1:0]  req_in;
  logic [127:0]  val_in;
  logic          hold_in;
  logic [31:0]   val_out;
  logic [N-1:0]  grant_out;
  logic          switch_out;

  logic [31:0]   v [4];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] v;
    logic        sw;
  } exp_t;

  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  assign val_in = {v[3], v[2], v[1], v[0]};

  seven_seg_display_arbiter #(
    .N_REQ        (N),
    .DWELL_CYCLES (DW),
    .IDLE_VAL     (32'h0000_0000)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .req_in     (req_in),
    .val_in     (val_in),
    .hold_in    (hold_in),
    .val_out    (val_out),
    .grant_out  (grant_out),
    .switch_out (switch_out)
  );

  function automatic exp_t mk(input int idx, input logic sw);
    exp_t e;
    if (idx < 0) begin
      e.g  = 4'b0000;
      e.v  = 32'h0000_0000;
      e.sw = 1'b0;
    end else begin
      e.g  = 4'(1 << idx);
      e.v  = v[idx];
      e.sw = sw;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    req_in   = '0;
    hold_in  = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n_in = 1'b1;
    req_in   = '0;
    hold_in  = 1'b0;
    for (int i = 0; i < 4; i++) v[i] = 32'h0;
    #2 rst_n_in = 1'b0;
    #2;
    sb.push_back(mk(-1, 1'b0));
    e = sb.pop_front();
    n_chk++;
    if ({grant_out, val_out, switch_out} !== e) begin
      n_fail++;
      $display("FAIL reset_assert: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
               grant_out, val_out, switch_out, e.g, e.v, e.sw);
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sb.push_back(mk(-1, 1'b0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    v[2]   = 32'h0000_1234;
    req_in = 4'b0100;
    for (int c = 0; c < 41; c++) begin
      if (c == 20) v[2] = 32'h0000_5678;
      sb.push_back(mk(2, c == 0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL single c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) v[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
    req_in = 4'b1110;
    for (int k = 1; k <= 40; k++) begin
      sb.push_back(mk(1 + ((k - 1) / DW) % 3, ((k - 1) % DW) == 0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL rotation k=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 k, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
    // grant 2 is at its last dwell cycle here; hold must keep it from rotating
    hold_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sb.push_back(mk(2, 1'b0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL hold c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
    hold_in = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      sb.push_back(mk((c < 8) ? 3 : 1, (c == 0) || (c == 8)));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL hold_release c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
  endtask

  task automatic test_drop();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) v[i] = 32'hD000_0000 + 32'(i);
    req_in = 4'b1100;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) req_in = 4'b1000;
      if (c == 7) req_in = 4'b0000;
      if (c < 4)      sb.push_back(mk(2, c == 0));
      else if (c < 7) sb.push_back(mk(3, c == 4));
      else            sb.push_back(mk(-1, 1'b0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL drop c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) v[i] = 32'hE000_0000 + 32'(i * 32'h10);
    req_in = 4'b0110;
    for (int k = 1; k <= 10; k++) begin
      sb.push_back(mk(1 + ((k - 1) / DW) % 2, ((k - 1) % DW) == 0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL pre_rotate k=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 k, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
    req_in = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      sb.push_back(mk((c < 8) ? 0 : 1, (c == 0) || (c == 8)));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL preempt c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
    // req 0 re-rises exactly on grant 1's expiry cycle: preemption must win
    req_in = 4'b0110;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) req_in = 4'b0111;
      sb.push_back((c < 6) ? mk(1, 1'b0) : mk(0, 1'b1));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL preempt_expiry c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) v[i] = 32'hF000_0000 + 32'(i * 32'h1000);
    req_in = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      sb.push_back(mk(1, c == 0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL arst_pre c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
    #3 rst_n_in = 1'b0;
    #1;
    sb.push_back(mk(-1, 1'b0));
    e = sb.pop_front();
    n_chk++;
    if ({grant_out, val_out, switch_out} !== e) begin
      n_fail++;
      $display("FAIL arst_mid: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
               grant_out, val_out, switch_out, e.g, e.v, e.sw);
    end
    req_in = 4'b1111;
    tick();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sb.push_back(mk(0, c == 0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({grant_out, val_out, switch_out} !== e) begin
        n_fail++;
        $display("FAIL arst_release c=%0d: got g=%b v=%h sw=%b, want g=%b v=%h sw=%b",
                 c, grant_out, val_out, switch_out, e.g, e.v, e.sw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_preempt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_arbiter.md
# seven_seg_display_arbiter

Time-shares the single 8-digit seven-segment display between up to N_REQ value sources: game score, high score, debug words and similar. It sits directly upstream of the seven-segment scan controller and drives that controller's 32-bit value input. It grants one requester at a time for a fixed dwell period and rotates round-robin among active requesters. Requester 0 is the urgent source and preempts on its rising request.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- DWELL_CYCLES, 100_000_000: cycles each grant is held before rotating (1 s at 100 MHz); must be ≥ 2.
- IDLE_VAL, 32'h0000_0000: value driven on val_out while nothing is granted.
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: reset, asynchronous assert, active-low.
- req_in, input, N_REQ: per-requester "want display" level.
- val_in, input, 32*N_REQ: flattened values; requester i occupies bits [32*i+31:32*i].
- hold_in, input, 1: freezes the dwell counter, so rotation stops while high.
- val_out, output, 32: registered value for the seven-segment controller.
- grant_out, output, N_REQ: registered one-hot grant; all-zero when idle.
- switch_out, output, 1: one-cycle pulse when a new requester is granted.

## Operation
- States: IDLE and SHOW.
- Reset values: state=IDLE, grant_out=0, val_out=IDLE_VAL, switch_out=0, dwell counter=0, last-grant pointer=N_REQ-1, req0 edge register=0.
- **IDLE → SHOW:** when any req_in bit is high. The winner is the first asserted index searching upward from (last+1) mod N_REQ, wrapping.
- **SHOW, dwell expiry:** the dwell counter runs 0..DWELL_CYCLES-1. At count DWELL_CYCLES-1:
  - if another requester is active, grant the next one in round-robin order after the current grant and reset the counter;
  - if only the current requester is active, keep the grant, reset the counter, and do not pulse switch_out.
- **SHOW, granted req drops:** on the next edge, grant the next active requester and reset the counter. If none is active, go to IDLE with grant_out=0 and val_out=IDLE_VAL.
- **Preemption:** a rising edge on req_in[0] (req_in[0]=1 while the registered previous value is 0), with another requester granted, forces grant to 0 on the next edge and resets the counter. Preemption overrides dwell expiry and drop in the same cycle.
- **hold_in:** high stops the counter only. Drop and preemption still switch.
- last-grant pointer: updated to the winner on every grant change.
- **val_out:** registered every cycle from the val_in slice selected by the next grant value. grant_out and val_out therefore change on the same edge. While a grant holds, val_out follows the live val_in with 1-cycle latency.
- **switch_out:** high for the cycle after any edge where grant_out becomes a different non-zero value. Not asserted on SHOW→IDLE.

## Timing
- Request-to-grant latency: 1 cycle from req_in sampled high in IDLE.
- Rotation period with ≥2 active requesters, hold_in=0: exactly DWELL_CYCLES cycles per grant.
- Reset mid-grant: outputs return to reset values asynchronously. The first grant after release starts its search at index 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- The shared package seven_seg_pkg holds:
  - SEG_VAL_W = 32;
  - the state enum (IDLE, SHOW);
  - a helper function computing the counter width, $clog2(DWELL_CYCLES).
- One combinational sub-module, seven_seg_rr_pick:
  - inputs: req vector and start index;
  - outputs: one-hot winner and a valid flag.
  - It is used for both the idle search and the rotation search.
- The top-level integration instantiates seven_seg_display_arbiter → existing scan controller.

## Test plan
Bench parameters: N_REQ=4, DWELL_CYCLES=8.
- **Reset idle:** hold rst_n_in=0, then release with req_in=0 → grant_out=0, val_out=0, switch_out=0 indefinitely.
- **Single requester:** req_in=4'b0100, val_in[2]=32'h0000_1234 → one cycle later grant_out=4'b0100, val_out=32'h1234, one switch_out pulse. No further pulses over 40 cycles.
- **Rotation:** req_in=4'b1110 from reset, with unique values per slice → grants 1,2,3,1,… each lasting exactly 8 cycles, one switch_out pulse per change. With hold_in high for 20 cycles, the grant is frozen.
- **Drop:** requester 2 granted and req_in[2] cleared at count 3 → grant moves to 3 on the next edge. Clearing all requests → IDLE with val_out=IDLE_VAL.
- **Preemption:** req_in=4'b0110 rotating, then req_in[0] raised → grant_out=4'b0001 next edge and counter reset. Holding req_in[0] high causes no repeated preemption, and rotation resumes 8 cycles later.
- **Async reset mid-dwell:** drop rst_n_in between edges → outputs clear before the next edge. After release with req_in=4'b1111 → first grant is 0.
